// File: rtl/prog_fetch.sv
// Program-store reader: sequences addresses, captures each word and presents it on valid/ready.
// Optional build macro PROG_FETCH_LOOP_EN makes the last word wrap to word 0 instead of ending.
module prog_fetch #(
  parameter int unsigned INSTR_WIDTH = 5,
  parameter int unsigned ADDR_WIDTH  = 4,
  parameter int unsigned PROG_LEN    = 16,
  parameter logic [INSTR_WIDTH-1:0] HALT_OP = '1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load_done,
  input  logic                   start,
  input  logic                   stop,
  output logic [ADDR_WIDTH-1:0]  address,
  input  logic [INSTR_WIDTH-1:0] instruction,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic                   busy,
  output logic                   done
);

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(PROG_LEN - 1);

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StDone} state_e;

  state_e                 r_state;
  state_e                 w_state_next;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [ADDR_WIDTH-1:0]  w_addr_next;
  logic [INSTR_WIDTH-1:0] r_instr;
  logic [INSTR_WIDTH-1:0] w_instr_next;
  logic                   w_abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_addr  <= '0;
      r_instr <= '0;
    end else begin
      r_state <= w_state_next;
      r_addr  <= w_addr_next;
      r_instr <= w_instr_next;
    end
  end

  // Abort outranks HALT detection and acceptance in every active state.
  always_comb begin
    w_state_next = r_state;
    w_addr_next  = r_addr;
    w_instr_next = r_instr;
    w_abort      = stop || !load_done;
    unique case (r_state)
      StIdle: begin
        w_addr_next = '0;
        if (start && load_done) w_state_next = StFetch;
      end
      StFetch: begin
        if (w_abort) begin
          w_state_next = StIdle;
          w_addr_next  = '0;
        end else if (instruction == HALT_OP) begin
          w_state_next = StDone;
          w_addr_next  = '0;
        end else begin
          w_instr_next = instruction;
          w_state_next = StPresent;
        end
      end
      StPresent: begin
        if (w_abort) begin
          w_state_next = StIdle;
          w_addr_next  = '0;
        end else if (instr_ready) begin
          if (r_addr == LastAddr) begin
`ifdef PROG_FETCH_LOOP_EN
            w_state_next = StFetch;
`else
            w_state_next = StDone;
`endif
            w_addr_next  = '0;
          end else begin
            w_state_next = StFetch;
            w_addr_next  = r_addr + ADDR_WIDTH'(1);
          end
        end
      end
      StDone: begin
        w_state_next = StIdle;
        w_addr_next  = '0;
      end
      default: begin
        w_state_next = StIdle;
        w_addr_next  = '0;
      end
    endcase
  end

  assign address     = r_addr;
  assign instr_out   = r_instr;
  assign instr_valid = (r_state == StPresent);
  assign busy        = (r_state == StFetch) || (r_state == StPresent);
  assign done        = (r_state == StDone);

endmodule

// File: tb/tb_prog_fetch.sv
// Self-checking bench for prog_fetch: directed scenarios plus randomized programs and ready
// patterns checked against a word-list model of the program.
module tb_prog_fetch;
  localparam int unsigned IW = 5;
  localparam int unsigned AW = 4;
  localparam int unsigned PL = 16;
  localparam logic [IW-1:0] HALT = 5'b11111;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load_done = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          instr_ready = 1'b0;
  logic [AW-1:0] address;
  logic [IW-1:0] instruction;
  logic [IW-1:0] instr_out;
  logic          instr_valid;
  logic          busy;
  logic          done;
  logic [IW-1:0] mem [PL];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int obs_q[$];
  int exp_q[$];
  int obs_fetch_cyc, obs_done_cyc, obs_done_cnt, obs_unstable, obs_valid_cyc, obs_stall_cyc;
  int obs_addr_after, obs_busy_after, obs_timeout;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign instruction = mem[address];

  prog_fetch #(
    .INSTR_WIDTH(IW),
    .ADDR_WIDTH (AW),
    .PROG_LEN   (PL),
    .HALT_OP    (HALT)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_done  (load_done),
    .start      (start),
    .stop       (stop),
    .address    (address),
    .instruction(instruction),
    .instr_out  (instr_out),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .busy       (busy),
    .done       (done)
  );

  // Reference: the delivered words are the program up to (not including) the first HALT.
  task automatic build_expected();
    exp_q.delete();
    for (int i = 0; i < PL; i++) begin
      if (mem[i] == HALT) break;
      exp_q.push_back(int'(mem[i]));
    end
  endtask

  // rdy_mode: 0 = ready high, 1 = random ready, 2 = ready low for 5 valid cycles on word 4.
  task automatic run_prog(input int rdy_mode, input int max_cyc);
    logic          prev_stall;
    logic [IW-1:0] prev_instr;
    obs_q.delete();
    obs_fetch_cyc = -1; obs_done_cyc = -1; obs_done_cnt = 0; obs_unstable = 0;
    obs_valid_cyc = 0; obs_stall_cyc = 0; obs_timeout = 1;
    obs_addr_after = -1; obs_busy_after = -1;
    prev_stall = 1'b0;
    prev_instr = '0;
    @(posedge clk); #1;
    start = 1'b1;
    instr_ready = (rdy_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < max_cyc; k++) begin
      @(negedge clk);
      if (busy && obs_fetch_cyc < 0) obs_fetch_cyc = cyc;
      if (prev_stall && (!instr_valid || instr_out !== prev_instr)) obs_unstable++;
      if (instr_valid) obs_valid_cyc++;
      if (instr_valid && instr_ready) obs_q.push_back(int'(instr_out));
      if (instr_valid && !instr_ready) begin
        obs_stall_cyc++;
        if (rdy_mode == 2 && address != 4'd4) obs_unstable++;
      end
      prev_stall = instr_valid && !instr_ready;
      prev_instr = instr_out;
      if (done) begin
        obs_done_cnt++;
        obs_done_cyc = cyc;
        obs_timeout = 0;
        break;
      end
      @(posedge clk); #1;
      case (rdy_mode)
        1:       instr_ready = 1'($urandom_range(0, 1));
        2:       instr_ready = !(address == 4'd4 && obs_stall_cyc < 5);
        default: instr_ready = 1'b1;
      endcase
    end
    if (obs_timeout == 0) begin
      @(posedge clk); #1;
      instr_ready = 1'b1;
      @(negedge clk);
      obs_addr_after = int'(address);
      obs_busy_after = int'(busy);
      if (done) obs_done_cnt++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (address !== '0 || instr_out !== '0 || instr_valid !== 1'b0 || busy !== 1'b0
        || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: addr=%0d out=%0d valid=%b busy=%b done=%b, required all 0",
               address, instr_out, instr_valid, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_done = 1'b1;
  endtask

  task automatic test_full_run();
    int nerr;
    for (int i = 0; i < PL; i++) mem[i] = IW'(i);
    build_expected();
    run_prog(0, 60);
    checks++;
    if (obs_timeout != 0) begin
      failures++; $display("FAIL full_timeout: no done within budget, required done");
    end
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      failures++; $display("FAIL full_count: got %0d words, required %0d", obs_q.size(), exp_q.size());
    end
    nerr = 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] != exp_q[i]) nerr++;
    checks++;
    if (nerr != 0) begin
      failures++; $display("FAIL full_sequence: %0d words differ, required 0", nerr);
    end
    checks++;
    if (obs_done_cyc - obs_fetch_cyc != 32) begin
      failures++; $display("FAIL full_done_latency: got %0d, required 32", obs_done_cyc - obs_fetch_cyc);
    end
    checks++;
    if (obs_valid_cyc != 16) begin
      failures++; $display("FAIL full_valid_cycles: got %0d, required 16", obs_valid_cyc);
    end
    checks++;
    if (obs_addr_after != 0 || obs_busy_after != 0 || obs_done_cnt != 1) begin
      failures++;
      $display("FAIL full_after: addr=%0d busy=%0d done_pulses=%0d, required 0 0 1",
               obs_addr_after, obs_busy_after, obs_done_cnt);
    end
  endtask

  task automatic test_halt();
    int nerr;
    for (int i = 0; i < PL; i++) mem[i] = IW'($urandom_range(0, 30));
    mem[3] = HALT;
    build_expected();
    run_prog(0, 60);
    nerr = (obs_q.size() != 3) ? 1 : 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] != exp_q[i]) nerr++;
    checks++;
    if (nerr != 0 || obs_timeout != 0) begin
      failures++;
      $display("FAIL halt_sequence: got %0d words (%0d errors, timeout=%0d), required 3 matching",
               obs_q.size(), nerr, obs_timeout);
    end
    checks++;
    if (obs_done_cyc - obs_fetch_cyc != 7) begin
      failures++; $display("FAIL halt_done_latency: got %0d, required 7", obs_done_cyc - obs_fetch_cyc);
    end
    checks++;
    if (obs_done_cnt != 1 || obs_addr_after != 0) begin
      failures++;
      $display("FAIL halt_after: done_pulses=%0d addr=%0d, required 1 0", obs_done_cnt, obs_addr_after);
    end
  endtask

  task automatic test_stall();
    int nerr;
    for (int i = 0; i < PL; i++) mem[i] = IW'(i);
    build_expected();
    run_prog(2, 80);
    nerr = (obs_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] != exp_q[i]) nerr++;
    checks++;
    if (nerr != 0 || obs_timeout != 0) begin
      failures++; $display("FAIL stall_sequence: %0d errors timeout=%0d, required 0 0", nerr, obs_timeout);
    end
    checks++;
    if (obs_stall_cyc != 5 || obs_unstable != 0) begin
      failures++;
      $display("FAIL stall_hold: stall_cycles=%0d unstable=%0d, required 5 0", obs_stall_cyc, obs_unstable);
    end
    checks++;
    if (obs_done_cyc - obs_fetch_cyc != 37) begin
      failures++; $display("FAIL stall_done_latency: got %0d, required 37", obs_done_cyc - obs_fetch_cyc);
    end
  endtask

  task automatic test_random();
    int  nerr;
    bit  has_halt;
    for (int it = 0; it < 8; it++) begin
      has_halt = 0;
      for (int i = 0; i < PL; i++) begin
        mem[i] = IW'($urandom_range(0, 31));
        if (mem[i] == HALT) has_halt = 1;
      end
`ifdef PROG_FETCH_LOOP_EN
      if (!has_halt) mem[$urandom_range(0, PL - 1)] = HALT;
`endif
      build_expected();
      run_prog(1, 400);
      nerr = (obs_q.size() != exp_q.size()) ? 1 : 0;
      for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] != exp_q[i]) nerr++;
      checks++;
      if (nerr != 0 || obs_timeout != 0 || obs_done_cnt != 1) begin
        failures++;
        $display("FAIL random_run%0d: got %0d words errors=%0d timeout=%0d done=%0d, required %0d 0 0 1",
                 it, obs_q.size(), nerr, obs_timeout, obs_done_cnt, exp_q.size());
      end
      checks++;
      if (obs_unstable != 0) begin
        failures++; $display("FAIL random_hold%0d: unstable=%0d, required 0", it, obs_unstable);
      end
    end
  endtask

  task automatic test_abort();
    bit found;
    bit seen;
    for (int i = 0; i < PL; i++) mem[i] = IW'(i);
    instr_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (instr_valid && address == 4'd7) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++; $display("FAIL abort_reach: address 7 never presented, required presented");
    end
    load_done = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0 || instr_valid !== 1'b0 || address !== '0 || done !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: busy=%b valid=%b addr=%0d done=%b, required 0 0 0 0",
               busy, instr_valid, address, done);
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) seen = 1;
    end
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy || done) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++; $display("FAIL abort_quiet: activity seen after abort or start without load_done, required none");
    end
    load_done = 1'b1;
  endtask

  task automatic test_reset_midrun();
    bit found;
    int nerr;
    for (int i = 0; i < PL; i++) mem[i] = IW'(i + 3);
    instr_ready = 1'b1;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    found = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (address == 4'd9) begin
        found = 1;
        break;
      end
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (!found || instr_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || address !== '0) begin
      failures++;
      $display("FAIL reset_midrun: found=%0d valid=%b busy=%b done=%b addr=%0d, required 1 0 0 0 0",
               found, instr_valid, busy, done, address);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mem[10] = HALT;
    build_expected();
    run_prog(0, 60);
    nerr = (obs_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) if (obs_q[i] != exp_q[i]) nerr++;
    checks++;
    if (nerr != 0 || obs_timeout != 0 || obs_q.size() == 0 || obs_q[0] != 3) begin
      failures++;
      $display("FAIL reset_restart: got %0d words errors=%0d timeout=%0d, required %0d from word 0",
               obs_q.size(), nerr, obs_timeout, exp_q.size());
    end
  endtask

`ifdef PROG_FETCH_LOOP_EN
  task automatic test_loop();
    int  got[$];
    int  nerr;
    bit  seen_done;
    for (int i = 0; i < PL; i++) mem[i] = IW'(i);
    instr_ready = 1'b1;
    seen_done = 0;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 100 && got.size() < 20; k++) begin
      @(negedge clk);
      if (instr_valid && instr_ready) got.push_back(int'(instr_out));
      if (done) seen_done = 1;
    end
    nerr = (got.size() != 20) ? 1 : 0;
    for (int i = 0; i < got.size(); i++) if (got[i] != i % 16) nerr++;
    checks++;
    if (nerr != 0 || seen_done) begin
      failures++;
      $display("FAIL loop_wrap: got %0d words errors=%0d done=%0d, required 20 0 0",
               got.size(), nerr, seen_done);
    end
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || instr_valid !== 1'b0 || address !== '0) begin
      failures++;
      $display("FAIL loop_stop: busy=%b valid=%b addr=%0d, required 0 0 0", busy, instr_valid, address);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < PL; i++) mem[i] = '0;
    test_reset();
    test_halt();
`ifndef PROG_FETCH_LOOP_EN
    test_full_run();
    test_stall();
`endif
    test_random();
    test_abort();
    test_reset_midrun();
`ifdef PROG_FETCH_LOOP_EN
    test_loop();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
